// File: rtl/register_file_multiport_if.sv
// Bus bundle for the multiport register file: write, reserve and read ports plus ready.
// The master side drives requests, the slave side (the register file) returns data and pending.
interface register_file_multiport_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int READ_PORTS  = 2,
    parameter int WRITE_PORTS = 2
);
    logic                              ready;
    logic [WRITE_PORTS-1:0]            write_enable;
    logic [WRITE_PORTS*ADDR_WIDTH-1:0] write_address;
    logic [WRITE_PORTS*DATA_WIDTH-1:0] write_data;
    logic                              reserve_enable;
    logic [ADDR_WIDTH-1:0]             reserve_address;
    logic [READ_PORTS-1:0]             read_enable;
    logic [READ_PORTS*ADDR_WIDTH-1:0]  read_address;
    logic [READ_PORTS*DATA_WIDTH-1:0]  read_data;
    logic [READ_PORTS-1:0]             read_pending;

    modport master (
        input  ready, read_data, read_pending,
        output write_enable, write_address, write_data,
               reserve_enable, reserve_address, read_enable, read_address
    );

    modport slave (
        output ready, read_data, read_pending,
        input  write_enable, write_address, write_data,
               reserve_enable, reserve_address, read_enable, read_address
    );
endinterface

// File: rtl/register_file_multiport.sv
// Parametrised register file with prioritised write ports, per-port write bypass,
// a post-reset clear sequencer and a per-register pending scoreboard for decode interlock.
module register_file_multiport #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int READ_PORTS  = 2,
    parameter int WRITE_PORTS = 2,
    parameter int ZERO_REG    = 1
) (
    input  logic clock,
    input  logic reset,
    register_file_multiport_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {CLEAR, READY} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] clear_index;
    logic [DEPTH-1:0]      pending;
    logic [DEPTH-1:0]      pending_next;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  active;

    assign active    = reset && (state == READY);
    assign bus.ready = active;

    // Control state: clear sequencer and the pending scoreboard.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= CLEAR;
            clear_index <= '0;
            pending     <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    clear_index <= clear_index + 1'b1;
                    if (clear_index == ADDR_WIDTH'(DEPTH - 1))
                        state <= READY;
                end
                READY: pending <= pending_next;
                default: state <= CLEAR;
            endcase
        end
    end

    // A reserve is applied after the write clears so a new producer supersedes the old one.
    always_comb begin
        pending_next = pending;
        for (int p = 0; p < WRITE_PORTS; p++) begin
            if (bus.write_enable[p])
                pending_next[bus.write_address[p*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
        end
        if (bus.reserve_enable)
            pending_next[bus.reserve_address] = 1'b1;
        if (ZERO_REG == 1)
            pending_next[0] = 1'b0;
    end

    // Array writes; the later port's assignment lands last, giving it priority.
    always_ff @(posedge clock) begin
        if (reset) begin
            if (state == CLEAR) begin
                mem[clear_index] <= '0;
            end else begin
                for (int p = 0; p < WRITE_PORTS; p++) begin
                    if (bus.write_enable[p] &&
                        !(ZERO_REG == 1 && bus.write_address[p*ADDR_WIDTH +: ADDR_WIDTH] == '0))
                        mem[bus.write_address[p*ADDR_WIDTH +: ADDR_WIDTH]] <=
                            bus.write_data[p*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    logic [ADDR_WIDTH-1:0] rd_addr [READ_PORTS];
    logic                  rd_hit  [READ_PORTS];

    always_comb begin
        bus.read_data    = '0;
        bus.read_pending = '0;
        for (int r = 0; r < READ_PORTS; r++) begin
            rd_addr[r] = bus.read_address[r*ADDR_WIDTH +: ADDR_WIDTH];
            rd_hit[r]  = 1'b0;
            if (active && bus.read_enable[r] && !(ZERO_REG == 1 && rd_addr[r] == '0)) begin
                for (int p = 0; p < WRITE_PORTS; p++) begin
                    if (bus.write_enable[p] &&
                        bus.write_address[p*ADDR_WIDTH +: ADDR_WIDTH] == rd_addr[r]) begin
                        rd_hit[r] = 1'b1;
                        bus.read_data[r*DATA_WIDTH +: DATA_WIDTH] =
                            bus.write_data[p*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                if (!rd_hit[r]) begin
                    bus.read_data[r*DATA_WIDTH +: DATA_WIDTH] = mem[rd_addr[r]];
                    bus.read_pending[r] = pending[rd_addr[r]];
                end
            end
        end
    end
endmodule
